// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer driving the ALU mode, datapath selects, register enables and memory strobes.
// Optional MU0_ILLEGAL_TRAP_EN: opcodes 8-15 halt the core and latch the Illegal flag until reset.
module mu0_control #(
  parameter int WAIT_STATES = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  output logic [1:0] M,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted
`ifdef MU0_ILLEGAL_TRAP_EN
  ,
  output logic       Illegal
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mem_op;
  logic       last;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Only fetch and LDA/STA/ADD/SUB touch memory, so only they stretch over wait states.
  assign mem_op = (state == FETCH) || ((state == EXECUTE) && (F[3:2] == 2'b00));
  assign last   = !mem_op || (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (mem_op && !last) ? cnt + 4'd1 : 4'd0;
    M         = 2'd0;
    X_sel     = 1'b0;
    Y_sel     = 1'b0;
    Addr_sel  = 1'b0;
    PC_En     = 1'b0;
    IR_En     = 1'b0;
    Acc_En    = 1'b0;
    Rd        = 1'b0;
    Wr        = 1'b0;
    Halted    = 1'b0;

    case (state)
      FETCH: begin
        Rd    = 1'b1;
        X_sel = 1'b1;
        M     = 2'd2;
        IR_En = last;
        PC_En = last;
        if (last) state_nxt = EXECUTE;
      end

      EXECUTE: begin
        if (last) state_nxt = FETCH;
        case (F)
          4'd0: begin
            Addr_sel = 1'b1;
            Rd       = 1'b1;
            Acc_En   = last;
          end
          4'd1: begin
            Addr_sel = 1'b1;
            Wr       = last;
          end
          4'd2, 4'd3: begin
            Addr_sel = 1'b1;
            Rd       = 1'b1;
            M        = (F == 4'd2) ? 2'd1 : 2'd3;
            Acc_En   = last;
          end
          4'd4: begin
            Y_sel = 1'b1;
            PC_En = 1'b1;
          end
          4'd5: begin
            Y_sel = 1'b1;
            PC_En = ~N;
          end
          4'd6: begin
            Y_sel = 1'b1;
            PC_En = ~Z;
          end
          4'd7: state_nxt = HALT;
          default: begin
`ifdef MU0_ILLEGAL_TRAP_EN
            state_nxt = HALT;
`else
            state_nxt = FETCH;
`endif
          end
        endcase
      end

      HALT: Halted = 1'b1;

      default: state_nxt = FETCH;
    endcase

    // Outputs are forced quiet while reset is held, so an abandoned access never completes.
    if (!Reset) begin
      M        = 2'd0;
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      Addr_sel = 1'b0;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      Acc_En   = 1'b0;
      Rd       = 1'b0;
      Wr       = 1'b0;
      Halted   = 1'b0;
    end
  end

`ifdef MU0_ILLEGAL_TRAP_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      Illegal <= 1'b0;
    else if ((state == EXECUTE) && F[3])
      Illegal <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mu0_control.sv
// Randomized bench for mu0_control: one instance without wait states, one with two wait states,
// each checked cycle by cycle against a per-instruction schedule built from the opcode table.
module tb_mu0_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_in [2];
  logic [3:0] f_in   [2];
  logic       n_in   [2];
  logic       z_in   [2];
  logic [1:0] m_o    [2];
  logic       xs_o [2], ys_o [2], as_o [2], pc_o [2], ir_o [2], acc_o [2], rd_o [2], wr_o [2], h_o [2];
  logic [10:0] obs   [2];
`ifdef MU0_ILLEGAL_TRAP_EN
  logic       ill_o  [2];
`endif

  logic ill_exp [2];
  logic halted  [2];
  int   n_cmp = 0;
  int   n_bad = 0;

  mu0_control #(.WAIT_STATES(0)) dut0 (
    .Clk(clk), .Reset(rst_in[0]), .F(f_in[0]), .N(n_in[0]), .Z(z_in[0]),
    .M(m_o[0]), .X_sel(xs_o[0]), .Y_sel(ys_o[0]), .Addr_sel(as_o[0]),
    .PC_En(pc_o[0]), .IR_En(ir_o[0]), .Acc_En(acc_o[0]),
    .Rd(rd_o[0]), .Wr(wr_o[0]), .Halted(h_o[0])
`ifdef MU0_ILLEGAL_TRAP_EN
    , .Illegal(ill_o[0])
`endif
  );

  mu0_control #(.WAIT_STATES(2)) dut2 (
    .Clk(clk), .Reset(rst_in[1]), .F(f_in[1]), .N(n_in[1]), .Z(z_in[1]),
    .M(m_o[1]), .X_sel(xs_o[1]), .Y_sel(ys_o[1]), .Addr_sel(as_o[1]),
    .PC_En(pc_o[1]), .IR_En(ir_o[1]), .Acc_En(acc_o[1]),
    .Rd(rd_o[1]), .Wr(wr_o[1]), .Halted(h_o[1])
`ifdef MU0_ILLEGAL_TRAP_EN
    , .Illegal(ill_o[1])
`endif
  );

  assign obs[0] = {m_o[0], xs_o[0], ys_o[0], as_o[0], pc_o[0], ir_o[0], acc_o[0], rd_o[0], wr_o[0], h_o[0]};
  assign obs[1] = {m_o[1], xs_o[1], ys_o[1], as_o[1], pc_o[1], ir_o[1], acc_o[1], rd_o[1], wr_o[1], h_o[1]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Vector order: M, X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Halted
  function automatic logic [10:0] pk(input logic [1:0] m, input logic xs, input logic ys, input logic asel,
                                     input logic pc, input logic ir, input logic acc, input logic rd,
                                     input logic wr, input logic h);
    return {m, xs, ys, asel, pc, ir, acc, rd, wr, h};
  endfunction

  function automatic logic [10:0] fetch_exp(input logic fin);
    return pk(2'd2, 1, 0, 0, fin, fin, 0, 1, 0, 0);
  endfunction

  function automatic logic [10:0] exec_exp(input logic [3:0] f, input logic n, input logic z, input logic fin);
    case (f)
      4'd0:    return pk(2'd0, 0, 0, 1, 0, 0, fin, 1, 0, 0);
      4'd1:    return pk(2'd0, 0, 0, 1, 0, 0, 0, 0, fin, 0);
      4'd2:    return pk(2'd1, 0, 0, 1, 0, 0, fin, 1, 0, 0);
      4'd3:    return pk(2'd3, 0, 0, 1, 0, 0, fin, 1, 0, 0);
      4'd4:    return pk(2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      4'd5:    return pk(2'd0, 0, 1, 0, ~n, 0, 0, 0, 0, 0);
      4'd6:    return pk(2'd0, 0, 1, 0, ~z, 0, 0, 0, 0, 0);
      default: return 11'd0;
    endcase
  endfunction

  task automatic cyc(input int d, input string tag, input logic [10:0] e);
    @(negedge clk);
    chk(tag, 32'(obs[d]), 32'(e));
`ifdef MU0_ILLEGAL_TRAP_EN
    chk({tag, "_illegal"}, 32'(ill_o[d]), 32'(ill_exp[d]));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(input int d);
    f_in[d] = 4'($urandom);
    n_in[d] = 1'($urandom);
    z_in[d] = 1'($urandom);
  endtask

  task automatic do_reset(input int d, input int ncyc);
    rst_in[d]  = 1'b0;
    ill_exp[d] = 1'b0;
    halted[d]  = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      rnd(d);
      cyc(d, "reset", 11'd0);
    end
    rst_in[d] = 1'b1;
  endtask

  task automatic do_fetch(input int d);
    int ws = (d == 1) ? 2 : 0;
    for (int k = 0; k <= ws; k++) begin
      rnd(d);
      cyc(d, "fetch", fetch_exp(k == ws));
    end
  endtask

  // One complete instruction; n/z are applied on the decisive execute cycle.
  task automatic do_instr(input int d, input logic [3:0] f, input logic n, input logic z);
    int ws  = (d == 1) ? 2 : 0;
    int len = (f <= 4'd3) ? ws + 1 : 1;
    do_fetch(d);
    f_in[d] = f;
    for (int k = 0; k < len; k++) begin
      n_in[d] = (k == len - 1) ? n : 1'($urandom);
      z_in[d] = (k == len - 1) ? z : 1'($urandom);
      cyc(d, "exec", exec_exp(f, n_in[d], z_in[d], k == len - 1));
    end
    if (f == 4'd7) halted[d] = 1'b1;
`ifdef MU0_ILLEGAL_TRAP_EN
    if (f >= 4'd8) begin
      halted[d]  = 1'b1;
      ill_exp[d] = 1'b1;
    end
`endif
  endtask

  task automatic do_halt(input int d, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      rnd(d);
      cyc(d, "halt", pk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
  endtask

  // STA abandoned by reset on its second wait cycle: Wr must never pulse.
  task automatic sta_abort(input int d);
    do_fetch(d);
    f_in[d] = 4'd1;
    cyc(d, "sta_w1", exec_exp(4'd1, 0, 0, 0));
    rst_in[d]  = 1'b0;
    ill_exp[d] = 1'b0;
    cyc(d, "sta_abort", 11'd0);
    cyc(d, "sta_abort", 11'd0);
    rst_in[d] = 1'b1;
  endtask

  task automatic random_run(input int d, input int ninstr);
    for (int i = 0; i < ninstr; i++) begin
      do_instr(d, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      if (halted[d]) begin
        do_halt(d, $urandom_range(1, 4));
        do_reset(d, $urandom_range(1, 3));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_in[d] = 1'b0; f_in[d] = '0; n_in[d] = 1'b0; z_in[d] = 1'b0;
      ill_exp[d] = 1'b0; halted[d] = 1'b0;
    end

    do_reset(0, 3);
    do_instr(0, 4'd2, 0, 0);
    do_instr(0, 4'd3, 0, 0);
    do_instr(0, 4'd5, 1, 0);
    do_instr(0, 4'd5, 0, 0);
    do_instr(0, 4'd6, 0, 1);
    do_instr(0, 4'd6, 0, 0);
    do_instr(0, 4'd0, 0, 0);
    do_instr(0, 4'd1, 0, 0);
    do_instr(0, 4'd4, 1, 1);
    do_instr(0, 4'd7, 0, 0);
    do_halt(0, 10);
    do_reset(0, 2);
    random_run(0, 60);
    rst_in[0] = 1'b0;

    do_reset(1, 3);
    do_instr(1, 4'd0, 0, 0);
    do_instr(1, 4'd1, 0, 0);
    do_instr(1, 4'd3, 0, 0);
    sta_abort(1);
    do_instr(1, 4'd5, 0, 1);
    do_instr(1, 4'd9, 0, 0);
    if (halted[1]) begin
      do_halt(1, 3);
      do_reset(1, 2);
    end
    random_run(1, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Fetch/execute sequencer for the MU0 processor. It drives the mode input of the MU0 ALU, the X/Y/address multiplexer selects, and the PC, IR and ACC register enables. It also drives the memory Rd/Wr strobes.
- Sits directly upstream of the ALU: it consumes the IR opcode field and the ACC flags, and produces the M code the ALU consumes.
- Supports optional memory wait states.

Parameters:
- WAIT_STATES, 0, number of extra cycles each memory-accessing state is held (0..15).

Ports:
- Clk  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-low reset.
- F  input  4  opcode field, IR[15:12].
- N  input  1  ACC negative flag (ACC[15]).
- Z  input  1  ACC zero flag (ACC == 0).
- M  output  2  ALU mode: 0 Q=Y, 1 Q=X+Y, 2 Q=X+1, 3 Q=X-Y.
- X_sel  output  1  ALU X source: 0 ACC, 1 PC.
- Y_sel  output  1  ALU Y source: 0 memory data, 1 IR[11:0] zero-extended.
- Addr_sel  output  1  memory address: 0 PC, 1 IR[11:0].
- PC_En  output  1  load PC from ALU Q.
- IR_En  output  1  load IR from memory data.
- Acc_En  output  1  load ACC from ALU Q.
- Rd  output  1  memory read strobe.
- Wr  output  1  memory write strobe (data = ACC).
- Halted  output  1  high in HALT state.

Behaviour:
- States: FETCH, EXECUTE, HALT. State and wait counter are registers; all outputs are combinational decodes of state, counter, F, N and Z.
- Reset:
  - Reset low forces state = FETCH and wait counter = 0, asynchronously.
  - While Reset is low, all enables, Rd, Wr and Halted are 0, and M/X_sel/Y_sel/Addr_sel are 0.
  - The first fetch begins on the first rising edge after Reset goes high.
- FETCH:
  - Addr_sel=0, Rd=1, X_sel=1, M=2, IR_En=1, PC_En=1.
  - Next state is EXECUTE.
- EXECUTE, decoded on F:
  - 0 LDA: Addr_sel=1, Rd=1, Y_sel=0, M=0, Acc_En=1.
  - 1 STA: Addr_sel=1, Wr=1.
  - 2 ADD: Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, M=1, Acc_En=1.
  - 3 SUB: same as ADD but M=3.
  - 4 JMP: Y_sel=1, M=0, PC_En=1.
  - 5 JGE: as JMP, with PC_En=~N.
  - 6 JNE: as JMP, with PC_En=~Z.
  - 7 STP: no enables; next state HALT.
  - Opcodes 0–6 return to FETCH.
- Wait states (apply to FETCH and to EXECUTE of LDA/STA/ADD/SUB):
  - The state is held for WAIT_STATES+1 cycles, counted by the wait counter.
  - Rd, address and selects stay stable throughout.
  - IR_En, PC_En, Acc_En and Wr assert only on the final cycle.
  - The counter clears on every state change.
- Jumps and STP take one cycle regardless of WAIT_STATES. N and Z are evaluated on the decisive cycle only.
- HALT: all enables and strobes 0, Halted=1. The block stays in HALT until Reset.
- Reset asserted mid-state, including mid-wait: the operation is abandoned; no enable or Wr pulse is issued after Reset falls.
- Opcodes 8–15 without the optional feature: one-cycle no-op, all enables 0, next state FETCH.
- Invariants:
  - Wr and Rd are never high together.
  - At most one of IR_En/Acc_En is high in any cycle.

Optional Feature:
- Macro MU0_ILLEGAL_TRAP_EN.
- When defined:
  - Opcodes 8–15 in EXECUTE move to HALT.
  - A registered output Illegal (1 bit) is set; it is cleared only by Reset.
  - Halted=1 in HALT as normal.
- When undefined: the Illegal port is absent, and opcodes 8–15 behave as the one-cycle no-op above.

Test Plan:
- Reset low for 3 cycles, then high, WAIT_STATES=0 -> during reset all enables/Rd/Wr=0. First cycle after release: Rd=1, M=2, X_sel=1, IR_En=1, PC_En=1. Next cycle is EXECUTE.
- F=2 (ADD) in EXECUTE -> Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, M=1, Acc_En=1, then FETCH. Repeat with F=3 -> M=3.
- F=5 with N=1, then N=0 -> PC_En=0, then PC_En=1. F=6 with Z=1/Z=0 -> PC_En=0/1. Each takes one cycle with M=0, Y_sel=1.
- WAIT_STATES=2, F=0 (LDA) -> EXECUTE lasts 3 cycles, Rd=1 throughout, Acc_En=1 only on cycle 3. FETCH also lasts 3 cycles, IR_En/PC_En only on cycle 3.
- F=7 (STP) -> HALT next cycle, Halted=1, no enables for 10 further cycles. Reset pulse -> FETCH resumes.
- WAIT_STATES=2, F=1 (STA): Reset asserted on wait cycle 2 -> Wr never pulses, and the state reads FETCH after release. With MU0_ILLEGAL_TRAP_EN, F=9 -> Illegal=1, Halted=1.
